// File: rtl/lane_deskew_if.sv
// lane_deskew_if: per-lane PHY inputs toward the deskew block, aligned word and status back.
interface lane_deskew_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_SKEW  = 3
);
    localparam int DLY_W = $clog2(MAX_SKEW + 1);
    logic [NUM_LANES-1:0]        lane_valid;
    logic [NUM_LANES*DATA_W-1:0] lane_data;
    logic [NUM_LANES*DATA_W-1:0] word_out;
    logic                        word_valid;
    logic                        locked;
    logic                        align_err;
    logic [NUM_LANES*DLY_W-1:0]  lane_delay;
    modport master (
        output lane_valid, lane_data,
        input  word_out, word_valid, locked, align_err, lane_delay
    );
    modport slave (
        input  lane_valid, lane_data,
        output word_out, word_valid, locked, align_err, lane_delay
    );
endinterface

// File: rtl/lane_deskew.sv
// lane_deskew: measures inter-lane skew from each lane's valid rising edge and delays
// every lane so all lanes present one aligned, concatenated word.
module lane_deskew #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_SKEW  = 3
) (
    input  logic         clk,
    input  logic         resetn,
    lane_deskew_if.slave bus
);
    localparam int DLY_W = $clog2(MAX_SKEW + 1);
    localparam int CNT_W = DLY_W + 1;
    localparam int W     = NUM_LANES * DATA_W;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SKEW);

    typedef enum logic [2:0] {IDLE, ARM, ACQ, LOCKED, WAIT} state_t;

    state_t               state_q, state_d;
    logic [NUM_LANES-1:0] tv_q [MAX_SKEW+1];
    logic [NUM_LANES-1:0] tv_d [MAX_SKEW+1];
    logic [W-1:0]         td_q [MAX_SKEW+1];
    logic [W-1:0]         td_d [MAX_SKEW+1];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     start_q [NUM_LANES];
    logic [CNT_W-1:0]     start_d [NUM_LANES];
    logic [DLY_W-1:0]     delay_q [NUM_LANES];
    logic [DLY_W-1:0]     delay_d [NUM_LANES];
    logic [NUM_LANES-1:0] seen_q, seen_d;
    logic [W-1:0]         word_q, word_d;
    logic                 word_valid_q, word_valid_d;
    logic                 locked_q, locked_d;
    logic                 err_q, err_d;
    logic                 primed_q;
    logic [NUM_LANES-1:0] rise, seen_now, av;
    logic [W-1:0]         ad;
    logic [CNT_W-1:0]     c;
    logic                 lock_now;

    always_comb begin
        tv_d[0] = bus.lane_valid;
        td_d[0] = bus.lane_data;
        for (int k = 1; k <= MAX_SKEW; k++) begin
            tv_d[k] = tv_q[k-1];
            td_d[k] = td_q[k-1];
        end
        rise     = tv_q[0] & ~tv_q[1];
        c        = (state_q == ARM) ? '0 : cnt_q + 1'b1;
        seen_now = seen_q | rise;
        state_d  = state_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        start_d  = start_q;
        delay_d  = delay_q;
        err_d    = 1'b0;
        lock_now = 1'b0;
        for (int l = 0; l < NUM_LANES; l++)
            if (rise[l] && !seen_q[l]) start_d[l] = c;
        // primed_q keeps a packet already in flight at reset release from being acquired mid-stream
        case (state_q)
            IDLE: begin
                seen_d = '0;
                if (primed_q && tv_q[0] == '0) state_d = ARM;
            end
            ARM: if (|rise) begin
                seen_d   = rise;
                cnt_d    = '0;
                state_d  = ACQ;
                lock_now = &rise;
            end
            ACQ: begin
                cnt_d  = c;
                seen_d = seen_now;
                if (|(seen_q & ~tv_q[0]) || c > MAX_C) begin
                    err_d   = 1'b1;
                    state_d = WAIT;
                end else lock_now = &seen_now;
            end
            WAIT: if (tv_q[0] == '0) state_d = IDLE;
            default: ;
        endcase
        if (lock_now) begin
            state_d = LOCKED;
            for (int l = 0; l < NUM_LANES; l++) delay_d[l] = DLY_W'(c - start_d[l]);
        end
        // the lock cycle already uses the fresh delays so beat 0 of every lane is kept
        av = '0;
        ad = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            av[l] = tv_q[delay_d[l]][l];
            ad[(NUM_LANES-1-l)*DATA_W +: DATA_W] = td_q[delay_d[l]][l*DATA_W +: DATA_W];
        end
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (lock_now || state_q == LOCKED) begin
            if (&av) begin
                word_valid_d = 1'b1;
                word_d       = ad;
            end else if (state_q == LOCKED) begin
                state_d = (|av) ? WAIT : IDLE;
                err_d   = |av;
            end
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            tv_q         <= '{default: '0};
            td_q         <= '{default: '0};
            cnt_q        <= '0;
            start_q      <= '{default: '0};
            delay_q      <= '{default: '0};
            seen_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            tv_q         <= tv_d;
            td_q         <= td_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            delay_q      <= delay_d;
            seen_q       <= seen_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            primed_q     <= 1'b1;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.locked     = locked_q;
    assign bus.align_err  = err_q;

    always_comb begin
        bus.lane_delay = '0;
        for (int l = 0; l < NUM_LANES; l++) bus.lane_delay[l*DLY_W +: DLY_W] = delay_q[l];
    end
endmodule

// File: tb/tb_lane_deskew.sv
// tb_lane_deskew: table of packet scenarios with hand-computed delays, word counts,
// first-valid timing and error pulses, plus a mid-packet reset sequence.
module tb_lane_deskew;
    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lane_deskew_if #(.NUM_LANES(4), .DATA_W(8), .MAX_SKEW(3)) b ();
    lane_deskew #(.NUM_LANES(4), .DATA_W(8), .MAX_SKEW(3)) dut (
        .clk(clk), .resetn(resetn), .bus(b)
    );

    typedef struct packed {
        logic [3:0][3:0] st;
        logic [3:0][3:0] ln;
        logic [7:0]      dly;
        int              nw;
        int              first;
        int              err;
    } pkt_t;

    pkt_t pkts [7];

    function automatic pkt_t mk(input int s0, s1, s2, s3, l0, l1, l2, l3,
                                input logic [7:0] dly, input int nw, first, err);
        pkt_t p;
        p.st    = {4'(s3), 4'(s2), 4'(s1), 4'(s0)};
        p.ln    = {4'(l3), 4'(l2), 4'(l1), 4'(l0)};
        p.dly   = dly;
        p.nw    = nw;
        p.first = first;
        p.err   = err;
        return p;
    endfunction

    function automatic logic [31:0] beat_word(input int k);
        return {8'(k), 8'(16 + k), 8'(32 + k), 8'(48 + k)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input pkt_t p, input int n);
        for (int l = 0; l < 4; l++) begin
            logic v;
            v = (n >= int'(p.st[l])) && (n < int'(p.st[l]) + int'(p.ln[l]));
            b.lane_valid[l] = v;
            b.lane_data[l*8 +: 8] = v ? 8'(l * 16 + n - int'(p.st[l])) : 8'hEE;
        end
    endtask

    task automatic run_pkt(input pkt_t p, input int id);
        int ncyc, nw, nl, ne, first;
        ncyc = 0;
        for (int l = 0; l < 4; l++)
            if (int'(p.st[l]) + int'(p.ln[l]) > ncyc) ncyc = int'(p.st[l]) + int'(p.ln[l]);
        ncyc += 10;
        nw = 0; nl = 0; ne = 0; first = -1;
        for (int n = 0; n < ncyc; n++) begin
            drive(p, n);
            @(posedge clk);
            #1;
            if (b.word_valid) begin
                if (first < 0) first = n;
                chk($sformatf("pkt%0d_word%0d", id, nw), b.word_out, beat_word(nw));
                nw++;
            end
            nl += int'(b.locked);
            ne += int'(b.align_err);
        end
        chk($sformatf("pkt%0d_nwords", id), nw, p.nw);
        chk($sformatf("pkt%0d_locked_cycles", id), nl, p.nw);
        chk($sformatf("pkt%0d_align_err", id), ne, p.err);
        chk($sformatf("pkt%0d_lane_delay", id), 32'(b.lane_delay), 32'(p.dly));
        chk($sformatf("pkt%0d_locked_end", id), 32'(b.locked), 0);
        if (p.nw > 0) chk($sformatf("pkt%0d_first", id), first, p.first);
    endtask

    initial begin
        pkts[0] = mk(0, 0, 0, 0, 6, 6, 6, 6, 8'h00, 6, 1, 0);
        pkts[1] = mk(0, 1, 3, 2, 6, 6, 6, 6, 8'h4B, 6, 4, 0);
        pkts[2] = mk(0, 1, 1, 4, 6, 6, 6, 6, 8'h4B, 0, 0, 1);
        pkts[3] = mk(2, 0, 1, 0, 5, 5, 5, 5, 8'h98, 5, 3, 0);
        pkts[4] = mk(0, 1, 3, 2, 6, 5, 6, 6, 8'h4B, 5, 4, 1);
        pkts[5] = mk(0, 2, 2, 2, 1, 4, 4, 4, 8'h4B, 0, 0, 1);
        pkts[6] = mk(1, 0, 0, 1, 4, 4, 4, 4, 8'h14, 4, 2, 0);

        resetn = 1'b0;
        b.lane_valid = '0;
        b.lane_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_word_out", b.word_out, 0);
        chk("reset_word_valid", 32'(b.word_valid), 0);
        chk("reset_locked", 32'(b.locked), 0);
        chk("reset_align_err", 32'(b.align_err), 0);
        chk("reset_lane_delay", 32'(b.lane_delay), 0);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_pkt(pkts[i], i);

        begin
            pkt_t r;
            int   after;
            r = mk(0, 0, 0, 0, 10, 10, 10, 10, 8'h00, 0, 0, 0);
            after = 0;
            for (int n = 0; n < 20; n++) begin
                drive(r, n);
                resetn = (n != 5);
                @(posedge clk);
                #1;
                if (n == 4) chk("rst_pre_valid", 32'(b.word_valid), 1);
                if (n == 5) begin
                    chk("rst_word_out", b.word_out, 0);
                    chk("rst_word_valid", 32'(b.word_valid), 0);
                    chk("rst_locked", 32'(b.locked), 0);
                    chk("rst_align_err", 32'(b.align_err), 0);
                    chk("rst_lane_delay", 32'(b.lane_delay), 0);
                end
                if (n > 5) after += int'(b.word_valid) + int'(b.locked) + int'(b.align_err);
            end
            resetn = 1'b1;
            chk("rst_remainder_ignored", after, 0);
        end

        run_pkt(mk(0, 1, 0, 0, 4, 4, 4, 4, 8'h51, 4, 2, 0), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
